// File: rtl/shrinker_scheduler_if.sv
// shrinker_scheduler_if: requester and response handshake bundle for the
// shrinker scheduler. Requesters and the response consumer use the master
// modport; the scheduler uses the slave modport.
interface shrinker_scheduler_if #(
    parameter int N = 512
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N:0]   req0_p;
    logic [N:0]   req0_q;

    logic         req1_valid;
    logic         req1_ready;
    logic [N:0]   req1_p;
    logic [N:0]   req1_q;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N:0]   rsp_p;
    logic [N:0]   rsp_q;

    modport master (
        output req0_valid, req0_p, req0_q,
        output req1_valid, req1_p, req1_q,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_p, rsp_q
    );

    modport slave (
        input  req0_valid, req0_p, req0_q,
        input  req1_valid, req1_p, req1_q,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_p, rsp_q
    );
endinterface

// File: rtl/shrinker_scheduler.sv
// shrinker_scheduler: aligns a shared slot-based shrinker datapath to its
// N_CYCLES slot cadence, arbitrates round-robin between two requesters at
// slot start, and returns results tagged with the requester id through a
// 2-entry response FIFO. Issue is credit-limited so a capture never finds
// the FIFO full.
// Optional build macro SHRINKER_SCHED_STATS_EN adds saturating 32-bit
// issued / idle-slot counters as extra outputs.
module shrinker_scheduler #(
    parameter int N        = 512,
    parameter int N_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    shrinker_scheduler_if.slave  bus,
    output logic                 o_sh_reset,
    output logic [N:0]           o_sh_p_in,
    output logic [N:0]           o_sh_q_in,
    input  logic [N:0]           i_sh_p_out,
    input  logic [N:0]           i_sh_q_out
`ifdef SHRINKER_SCHED_STATS_EN
    ,
    output logic [31:0]          o_issued_count,
    output logic [31:0]          o_idle_slot_count
`endif
);

    localparam int PW = (N_CYCLES > 2) ? $clog2(N_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(N_CYCLES - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_phase;

    logic            r_inflight;
    logic            r_inflight_id;
    logic            r_rr_ptr;

    logic            r_fifo_id [2];
    logic [N:0]      r_fifo_p  [2];
    logic [N:0]      r_fifo_q  [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_start;
    logic [1:0]      w_occupancy;
    logic            w_issue_ok;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_grant;
    logic            w_contend;
    logic            w_push;
    logic            w_pop;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // FSM next state; INIT holds the datapath in reset for exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        o_sh_reset  = 1'b0;
        case (r_state)
            ST_INIT: begin
                o_sh_reset  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Free-running slot phase, restarted at 0 on entry to RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_phase <= '0;
        else if (r_state == ST_INIT)   r_phase <= '0;
        else if (r_phase == PHASE_LAST) r_phase <= '0;
        else                           r_phase <= r_phase + 1'b1;
    end

    // Slot-start arbitration; credits count both queued and in-flight jobs
    always_comb begin
        w_start     = (r_state == ST_RUN) && (r_phase == '0);
        w_occupancy = r_count + 2'(r_inflight);
        w_issue_ok  = w_start && (w_occupancy <= 2'd1);
        w_grant0    = w_issue_ok && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
        w_grant1    = w_issue_ok && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
        w_grant     = w_grant0 || w_grant1;
        w_contend   = w_issue_ok && bus.req0_valid && bus.req1_valid;
        w_push      = w_start && r_inflight;
        w_pop       = (r_count != 2'd0) && bus.rsp_ready;

        bus.req0_ready = w_grant0;
        bus.req1_ready = w_grant1;

        o_sh_p_in = '0;
        o_sh_q_in = '0;
        if (w_grant0) begin
            o_sh_p_in = bus.req0_p;
            o_sh_q_in = bus.req0_q;
        end else if (w_grant1) begin
            o_sh_p_in = bus.req1_p;
            o_sh_q_in = bus.req1_q;
        end
    end

    // In-flight tracking and round-robin pointer, updated only at slot start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight    <= 1'b0;
            r_inflight_id <= 1'b0;
            r_rr_ptr      <= 1'b0;
        end else if (w_start) begin
            r_inflight    <= w_grant;
            r_inflight_id <= w_grant1;
            if (w_contend) r_rr_ptr <= ~r_rr_ptr;
        end
    end

    // Response FIFO: capture at slot start, pop on consumer handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_id[i] <= 1'b0;
                r_fifo_p[i]  <= '0;
                r_fifo_q[i]  <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_id[r_wr_ptr] <= r_inflight_id;
                r_fifo_p[r_wr_ptr]  <= i_sh_p_out;
                r_fifo_q[r_wr_ptr]  <= i_sh_q_out;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO head presentation
    always_comb begin
        bus.rsp_valid = (r_count != 2'd0);
        bus.rsp_id    = r_fifo_id[r_rd_ptr];
        bus.rsp_p     = r_fifo_p[r_rd_ptr];
        bus.rsp_q     = r_fifo_q[r_rd_ptr];
    end

`ifdef SHRINKER_SCHED_STATS_EN
    logic [31:0] r_issued_count;
    logic [31:0] r_idle_slot_count;

    // Saturating grant and idle-slot counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issued_count    <= '0;
            r_idle_slot_count <= '0;
        end else begin
            if (w_grant && (r_issued_count != '1))
                r_issued_count <= r_issued_count + 1'b1;
            if (w_start && !w_grant && (r_idle_slot_count != '1))
                r_idle_slot_count <= r_idle_slot_count + 1'b1;
        end
    end

    assign o_issued_count    = r_issued_count;
    assign o_idle_slot_count = r_idle_slot_count;
`endif

endmodule

// File: tb/tb_shrinker_scheduler.sv
// tb_shrinker_scheduler: randomized bench for shrinker_scheduler with a
// stub datapath (p+1, q+2 after one slot) and a slot-level reference model
// built on a cycle index, an in-flight job record and a response queue.
module tb_shrinker_scheduler;
    localparam int N  = 8;
    localparam int NC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shrinker_scheduler_if #(.N(N)) bus ();

    logic       sh_reset;
    logic [N:0] sh_p_in, sh_q_in, sh_p_out, sh_q_out;
`ifdef SHRINKER_SCHED_STATS_EN
    logic [31:0] issued_count, idle_slot_count;
`endif

    shrinker_scheduler #(.N(N), .N_CYCLES(NC)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_sh_reset (sh_reset),
        .o_sh_p_in  (sh_p_in),
        .o_sh_q_in  (sh_q_in),
        .i_sh_p_out (sh_p_out),
        .i_sh_q_out (sh_q_out)
`ifdef SHRINKER_SCHED_STATS_EN
        ,
        .o_issued_count    (issued_count),
        .o_idle_slot_count (idle_slot_count)
`endif
    );

    // Stub datapath: result of a slot-start input appears NC cycles later
    logic [N:0] stub_p [NC];
    logic [N:0] stub_q [NC];
    always @(posedge clk) begin
        if (sh_reset) begin
            for (int i = 0; i < NC; i++) begin
                stub_p[i] <= '0;
                stub_q[i] <= '0;
            end
        end else begin
            stub_p[0] <= sh_p_in + (N+1)'(1);
            stub_q[0] <= sh_q_in + (N+1)'(2);
            for (int i = 1; i < NC; i++) begin
                stub_p[i] <= stub_p[i-1];
                stub_q[i] <= stub_q[i-1];
            end
        end
    end
    assign sh_p_out = stub_p[NC-1];
    assign sh_q_out = stub_q[NC-1];

    typedef struct {
        bit         id;
        logic [N:0] p;
        logic [N:0] q;
    } rsp_t;

    rsp_t       m_fifo[$];
    int         k;
    bit         m_inf, m_inf_id, m_rr;
    logic [N:0] m_inf_p, m_inf_q;
    longint     m_issued, m_idle;
    bit         hv [2];
    logic [N:0] hp [2];
    logic [N:0] hq [2];
    int         p_valid, p_rdy;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_fifo.delete();
        m_inf    = 1'b0;
        m_inf_id = 1'b0;
        m_rr     = 1'b0;
        m_issued = 0;
        m_idle   = 0;
    endtask

    // Held requests keep valid and operands until accepted
    task automatic drive_inputs();
        for (int i = 0; i < 2; i++) begin
            if (!hv[i] && ($urandom_range(99) < p_valid)) begin
                hv[i] = 1'b1;
                hp[i] = (N+1)'($urandom);
                hq[i] = (N+1)'($urandom);
            end
        end
        bus.req0_valid = hv[0];
        bus.req0_p     = hp[0];
        bus.req0_q     = hq[0];
        bus.req1_valid = hv[1];
        bus.req1_p     = hp[1];
        bus.req1_q     = hq[1];
        bus.rsp_ready  = ($urandom_range(99) < p_rdy);
    endtask

    task automatic check_reset_values();
        check_val("rst_req0_ready", bus.req0_ready, 0);
        check_val("rst_req1_ready", bus.req1_ready, 0);
        check_val("rst_rsp_valid",  bus.rsp_valid,  0);
        check_val("rst_rsp_id",     bus.rsp_id,     0);
        check_val("rst_rsp_p",      bus.rsp_p,      0);
        check_val("rst_rsp_q",      bus.rsp_q,      0);
        check_val("rst_sh_reset",   sh_reset,       1);
        check_val("rst_sh_p_in",    sh_p_in,        0);
        check_val("rst_sh_q_in",    sh_q_in,        0);
`ifdef SHRINKER_SCHED_STATS_EN
        check_val("rst_issued",     issued_count,    0);
        check_val("rst_idle",       idle_slot_count, 0);
`endif
    endtask

    // Called just after a rising edge; releases reset so the current cycle is INIT
    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        #2;
        check_reset_values();
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        bit         init, start, ok, g0, g1;
        int         ph;
        logic [N:0] ep, eq;
        rsp_t       r;
        drive_inputs();
        @(negedge clk);
        init  = (k == 0);
        ph    = init ? 0 : (k - 1) % NC;
        start = !init && (ph == 0);
        ok    = start && ((m_fifo.size() + int'(m_inf)) <= 1);
        g0    = ok && hv[0] && (!hv[1] || !m_rr);
        g1    = ok && hv[1] && (!hv[0] ||  m_rr);
        ep    = g0 ? hp[0] : (g1 ? hp[1] : '0);
        eq    = g0 ? hq[0] : (g1 ? hq[1] : '0);

        check_val("req0_ready", bus.req0_ready, g0);
        check_val("req1_ready", bus.req1_ready, g1);
        check_val("sh_reset",   sh_reset,       init);
        check_val("sh_p_in",    sh_p_in,        ep);
        check_val("sh_q_in",    sh_q_in,        eq);
        check_val("rsp_valid",  bus.rsp_valid,  m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check_val("rsp_id", bus.rsp_id, m_fifo[0].id);
            check_val("rsp_p",  bus.rsp_p,  m_fifo[0].p);
            check_val("rsp_q",  bus.rsp_q,  m_fifo[0].q);
        end
`ifdef SHRINKER_SCHED_STATS_EN
        check_val("issued_count",    issued_count,    m_issued);
        check_val("idle_slot_count", idle_slot_count, m_idle);
`endif

        if ((m_fifo.size() != 0) && bus.rsp_ready) void'(m_fifo.pop_front());
        if (start && m_inf) begin
            r.id = m_inf_id;
            r.p  = m_inf_p + (N+1)'(1);
            r.q  = m_inf_q + (N+1)'(2);
            m_fifo.push_back(r);
        end
        if (start) begin
            m_inf = g0 || g1;
            if (g0 || g1) begin
                m_inf_id = g1;
                m_inf_p  = ep;
                m_inf_q  = eq;
            end
            if (g0 || g1) m_issued++;
            else          m_idle++;
        end
        if (ok && hv[0] && hv[1]) m_rr = !m_rr;
        if (g0) hv[0] = 1'b0;
        if (g1) hv[1] = 1'b0;

        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run(input int ncyc, input int pv, input int pr);
        p_valid = pv;
        p_rdy   = pr;
        for (int i = 0; i < ncyc; i++) step();
    endtask

    initial begin
        hv[0] = 1'b0; hv[1] = 1'b0;
        hp[0] = '0;   hp[1] = '0;
        hq[0] = '0;   hq[1] = '0;
        p_valid = 0;
        p_rdy   = 100;
        drive_inputs();
        model_reset();
        #1;
        apply_reset(2);

        run(40, 50, 80);    // mixed random traffic
        run(60, 100, 100);  // continuous contention
        run(40, 100, 0);    // backpressure until FIFO full
        run(30, 100, 100);  // drain and resume
        run(10, 100, 100);
        apply_reset(2);     // reset while jobs are in flight
        run(20, 30, 100);
        run(150, 40, 50);   // random traffic with random consumer stalls
        run(20, 0, 100);    // idle slots
        run(80, 70, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time bound");
        $fatal(1);
    end
endmodule

// File: doc/shrinker_scheduler.md
# shrinker_scheduler

Two-requester scheduler for the slot-based shrinker stage of the OM-Pipe multiplier. It aligns a shared shrinker datapath to its fixed N_CYCLES-cycle slot cadence and arbitrates round-robin between two operand sources. It issues at most one (p, q) pair per slot and returns each result with the originating requester id through a 2-entry response FIFO with backpressure. It sits between the operand producers and the shrinker instance, and owns that instance's synchronous reset.

## Interface
- N, 512, operand width; p/q buses are N+1 bits
- N_CYCLES, 4, datapath slot length in cycles (>= 2); must match the shrinker instance
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_ready / req1_ready  out  1  pair accepted this cycle (valid && ready)
- req0_p, req0_q / req1_p, req1_q  in  N+1  operand pairs
- sh_reset  out  1  active-high synchronous reset to the shrinker datapath
- sh_p_in, sh_q_in  out  N+1  datapath operand inputs
- sh_p_out, sh_q_out  in  N+1  datapath result outputs
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  1  requester that issued the head job
- rsp_p, rsp_q  out  N+1  head result

## Operation
- FSM states:
  - INIT: sh_reset=1, entered on reset; unconditional -> RUN next cycle, phase=0.
  - RUN: free-running phase counter 0..N_CYCLES-1, wraps to 0. Phase 0 is the datapath START cycle.
- Issue (RUN, phase 0 only): issue_ok = (fifo_count + inflight) <= 1.
  - If only one reqX_valid and issue_ok: grant X.
  - If both valid: grant rr_ptr, then rr_ptr <= other.
  - Granted port sees ready=1 for that cycle only. sh_p_in/sh_q_in = granted operands, combinational from the granted port.
  - No grant: sh_p_in/sh_q_in = 0.
  - inflight <= granted; inflight_id <= granted port.
- Ready is 0 outside phase 0, in INIT, and when issue_ok=0. A requester holding valid waits for a later slot; it is not dropped.
- Capture (RUN, phase 0, inflight=1): push {inflight_id, sh_p_out, sh_q_out} into the FIFO. Capture happens in the same cycle as any new issue.
- FIFO: 2 entries, wrap-around pointers, pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle is legal; count is unchanged.
  - The credit rule guarantees a push never finds the FIFO full.
- rr_ptr updates only on contention. Reset value 0, so req0 wins the first tie.

## Timing
- Reset values: ready=0 on both ports, rsp_valid=0, rsp_id=0, rsp_p/q=0, sh_reset=1, sh_p_in/q_in=0, phase=0, inflight=0, fifo_count=0, rr_ptr=0.
- Reset release: the first clock is in INIT with sh_reset=1. The next cycle is RUN phase 0, and the first issue is possible there.
- Latency: accept at cycle t (phase 0) -> capture at t+N_CYCLES -> rsp_valid=1 at t+N_CYCLES+1 if the FIFO was empty.
- Throughput: one job per N_CYCLES cycles sustained while rsp_ready=1.
- Backpressure:
  - With fifo_count=2, no issue occurs.
  - With fifo_count=1 and inflight=1, no issue occurs.
- Reset mid-operation: the in-flight job and FIFO contents are discarded, and the datapath is re-reset via INIT. No response is emitted for the discarded jobs.

## Configuration
- SHRINKER_SCHED_STATS_EN defined:
  - Adds 32-bit outputs issued_count and idle_slot_count, both cleared by reset and saturating at all-ones.
  - issued_count increments on every grant.
  - idle_slot_count increments at each phase 0 in RUN with no grant.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
All scenarios use N=8, N_CYCLES=4, and a stub datapath that returns sh_p_in+1 and sh_q_in+2 at the next phase 0.
- Single job: req0 p=0x05, q=0x10 held valid from reset release. Expect:
  - ready at the first RUN cycle.
  - rsp_valid 5 cycles later with rsp_id=0, rsp_p=0x06, rsp_q=0x12.
- Contention: both ports valid continuously with rsp_ready=1. Expect:
  - grants alternate 0,1,0,1 on consecutive phase-0 cycles, 4 cycles apart.
  - rsp_id sequence 0,1,0,1.
- Backpressure: req0 always valid, rsp_ready=0. Expect:
  - exactly 2 grants, then ready stays 0 and the FIFO holds 2 entries.
  - after rsp_ready=1, two pops, then issue resumes at the next phase 0.
- Off-phase request: req1 asserts valid at phase 2. Expect ready=0 until the next phase 0, then acceptance with operands unchanged.
- Reset mid-job: assert reset 2 cycles after a grant. Expect:
  - all outputs return to their reset values and no rsp_valid for that job.
  - sh_reset=1 for one cycle after release.
- STATS_EN build: 3 grants plus 2 empty slots. Expect issued_count=3 and idle_slot_count=2.
